// File: rtl/cv32e40x_fetch_queue.sv
// Instruction prefetch queue feeding the IF stage from the instruction OBI adapter.
// Issues sequential word-aligned fetches, counts in-flight transactions, buffers
// responses in a small FIFO and discards responses that belong to a pre-branch stream.

module cv32e40x_fetch_queue #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        trans_valid_o,
  input  logic        trans_ready_i,
  output logic [31:0] trans_addr_o,
  input  logic        resp_valid_i,
  input  logic [31:0] resp_rdata_i,
  input  logic        resp_err_i,
  output logic        fetch_valid_o,
  input  logic        fetch_ready_i,
  output logic [31:0] fetch_rdata_o,
  output logic        fetch_err_o,
  output logic [31:0] fetch_addr_o,
  output logic        busy_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [31:0]     r_req_addr;
  logic [31:0]     r_resp_addr;
  logic [CW-1:0]   r_out_cnt;
  logic [CW-1:0]   r_discard_cnt;
  logic [CW-1:0]   r_fifo_cnt;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [31:0]     r_mem_data [DEPTH];
  logic            r_mem_err  [DEPTH];
  logic [31:0]     r_mem_addr [DEPTH];

  logic [CW:0]     w_occ;
  logic            w_accept;
  logic            w_drop;
  logic            w_push;
  logic            w_pop;
  logic [31:0]     w_target;
  logic            w_unused_addr_bits;

  // Circular pointer advance that also works for non-power-of-two depths.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  // In-flight plus buffered words bound how many new requests may be issued.
  assign w_occ    = {1'b0, r_out_cnt} + {1'b0, r_fifo_cnt};
  assign w_accept = trans_valid_o && trans_ready_i;
  assign w_drop   = (r_discard_cnt != '0);
  assign w_push   = resp_valid_i && !branch_i && !w_drop;
  assign w_pop    = fetch_valid_o && fetch_ready_i;
  assign w_target = {branch_addr_i[31:2], 2'b00};
  assign w_unused_addr_bits = ^branch_addr_i[1:0];

  assign trans_addr_o  = r_req_addr;
  assign fetch_valid_o = (r_fifo_cnt != '0) && !branch_i;
  assign fetch_rdata_o = r_mem_data[r_rd_ptr];
  assign fetch_err_o   = r_mem_err[r_rd_ptr];
  assign fetch_addr_o  = r_mem_addr[r_rd_ptr];
  assign busy_o        = (r_out_cnt != '0) || (r_fifo_cnt != '0);

  // Fetch state register; leaving IDLE requires a first branch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and request-valid decode; a branch cycle never issues a request.
  always_comb begin
    w_state_nxt   = r_state;
    trans_valid_o = 1'b0;
    case (r_state)
      IDLE: begin
        if (branch_i) begin
          w_state_nxt = FETCH;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      FETCH: begin
        w_state_nxt   = FETCH;
        trans_valid_o = !branch_i && (w_occ < (CW + 1)'(DEPTH));
      end
      default: begin
        w_state_nxt   = IDLE;
        trans_valid_o = 1'b0;
      end
    endcase
  end

  // Request/response address tracking, redirected together on a branch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_req_addr  <= 32'h0000_0000;
      r_resp_addr <= 32'h0000_0000;
    end else if (branch_i) begin
      r_req_addr  <= w_target;
      r_resp_addr <= w_target;
    end else begin
      if (w_accept) begin
        r_req_addr <= r_req_addr + 32'd4;
      end
      if (w_push) begin
        r_resp_addr <= r_resp_addr + 32'd4;
      end
    end
  end

  // Outstanding count keeps including stale transactions so back-to-back branches add up.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_cnt     <= '0;
      r_discard_cnt <= '0;
    end else begin
      if (w_accept && !resp_valid_i) begin
        r_out_cnt <= r_out_cnt + CW'(1);
      end else if (!w_accept && resp_valid_i) begin
        r_out_cnt <= r_out_cnt - CW'(1);
      end
      if (branch_i) begin
        r_discard_cnt <= r_out_cnt - CW'(resp_valid_i);
      end else if (resp_valid_i && w_drop) begin
        r_discard_cnt <= r_discard_cnt - CW'(1);
      end
    end
  end

  // Response FIFO; a branch flushes it, push and pop may coincide.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem_data[i] <= 32'h0000_0000;
        r_mem_err[i]  <= 1'b0;
        r_mem_addr[i] <= 32'h0000_0000;
      end
    end else if (branch_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem_data[r_wr_ptr] <= resp_rdata_i;
        r_mem_err[r_wr_ptr]  <= resp_err_i;
        r_mem_addr[r_wr_ptr] <= r_resp_addr;
        r_wr_ptr             <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      if (w_push && !w_pop) begin
        r_fifo_cnt <= r_fifo_cnt + CW'(1);
      end else if (!w_push && w_pop) begin
        r_fifo_cnt <= r_fifo_cnt - CW'(1);
      end
    end
  end

  cv32e40x_fetch_queue_chk #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_chk (
    .clk           (clk),
    .rst_n         (rst_n),
    .out_cnt       (r_out_cnt),
    .fifo_cnt      (r_fifo_cnt),
    .discard_cnt   (r_discard_cnt),
    .resp_valid    (resp_valid_i),
    .unused_branch (w_unused_addr_bits)
  );

endmodule

// Occupancy and protocol invariants of the fetch queue.
module cv32e40x_fetch_queue_chk #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = 2
) (
  input logic          clk,
  input logic          rst_n,
  input logic [CW-1:0] out_cnt,
  input logic [CW-1:0] fifo_cnt,
  input logic [CW-1:0] discard_cnt,
  input logic          resp_valid,
  input logic          unused_branch
);

  a_occupancy: assert property (@(posedge clk) disable iff (!rst_n)
    (({1'b0, out_cnt} + {1'b0, fifo_cnt}) <= (CW + 1)'(DEPTH)));

  a_discard_le_out: assert property (@(posedge clk) disable iff (!rst_n)
    (discard_cnt <= out_cnt));

  a_no_unexpected_resp: assert property (@(posedge clk) disable iff (!rst_n)
    (resp_valid |-> (out_cnt != '0)));

endmodule

// File: doc/cv32e40x_fetch_queue.md
Name: cv32e40x_fetch_queue

Overview:
Instruction prefetch queue directly upstream of the instruction OBI adapter.
- Generates sequential word-aligned fetch requests on the adapter's transaction request interface.
- Tracks outstanding transactions and buffers responses in a small FIFO for the IF stage.
- On a branch, redirects fetching and discards responses to stale in-flight requests.

Parameters:
DEPTH, 2, FIFO entries; also the maximum number of outstanding plus buffered words (≥1).

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
branch_i  in  1  redirect fetch (also the required start after reset)
branch_addr_i  in  32  redirect target; bits [1:0] ignored
trans_valid_o  out  1  fetch request valid to OBI adapter
trans_ready_i  in  1  OBI adapter accepts request
trans_addr_o  out  32  word-aligned fetch address
resp_valid_i  in  1  fetch response valid (always accepted)
resp_rdata_i  in  32  response instruction word
resp_err_i  in  1  response bus error
fetch_valid_o  out  1  FIFO head valid to IF stage
fetch_ready_i  in  1  IF stage pops head
fetch_rdata_o  out  32  head instruction word
fetch_err_o  out  1  head bus-error flag
fetch_addr_o  out  32  address of head word
busy_o  out  1  outstanding transactions or FIFO non-empty

Behaviour:
Reset and start
- Reset is synchronous, active-low, on clk only.
- All state clears on reset: state=IDLE, req_addr_q=0, resp_addr_q=0, out_cnt_q=0, discard_cnt_q=0, FIFO empty.
- Reset values of outputs: all outputs 0.
- IDLE: trans_valid_o=0. Any branch_i moves to FETCH. No return to IDLE except via reset.
- Reset mid-operation drops all in-flight state. The bus is reset together with this block, so no stale responses follow.

Request side
- trans_addr_o = req_addr_q.
- trans_valid_o = (state==FETCH) && !branch_i && (out_cnt_q + fifo_cnt < DEPTH).
- Once asserted, trans_valid_o and trans_addr_o stay stable until trans_ready_i or branch_i.
- Accept = trans_valid_o && trans_ready_i. On accept: req_addr_q += 4, wrapping 0xFFFF_FFFC→0x0000_0000; out_cnt_q += 1.

Response side
- Every resp_valid_i decrements out_cnt_q.
- Accept and response in the same cycle leave out_cnt_q unchanged.
- If discard_cnt_q>0: decrement discard_cnt_q and drop the response.
- Otherwise push {resp_rdata_i, resp_err_i, resp_addr_q} into the FIFO, then resp_addr_q += 4 with wrap.
- Error responses are pushed like normal ones; fetching continues.
- Latency: resp_valid_i to fetch_valid_o is 1 cycle. There is no combinational bypass.

Consumer side
- fetch_valid_o = FIFO non-empty && !branch_i.
- fetch_rdata_o, fetch_err_o and fetch_addr_o come from the FIFO head.
- Pop = fetch_valid_o && fetch_ready_i.
- Push and pop in the same cycle are allowed, including when the FIFO is full.
- The FIFO cannot overflow by construction.

Branch (highest priority, takes effect at the next edge)
- FIFO cleared.
- req_addr_q and resp_addr_q ← {branch_addr_i[31:2], 2'b00}.
- discard_cnt_q ← out_cnt_q − (resp_valid_i ? 1 : 0). A response in the branch cycle is dropped.
- No accept can occur in the branch cycle (trans_valid_o is forced to 0).
- Back-to-back branches accumulate correctly because out_cnt_q still counts discarded transactions.

Other
- busy_o = (out_cnt_q != 0) || FIFO non-empty.
- Assertions: out_cnt_q+fifo_cnt ≤ DEPTH; discard_cnt_q ≤ out_cnt_q; no resp_valid_i while out_cnt_q==0.

Test Plan:
- Reset, branch_i to 0x100, trans_ready_i=1, response 1 cycle after each accept, fetch_ready_i=1 → requests 0x100, 0x104, 0x108…; fetch_addr_o follows one cycle after each response.
- DEPTH=2, fetch_ready_i=0, responses immediate → exactly 2 accepts (0x100, 0x104), then trans_valid_o=0. After 1 pop, one new request to 0x108.
- trans_ready_i=0 for 5 cycles → trans_valid_o=1 and trans_addr_o=0x100 held constant throughout.
- 2 outstanding, branch_i to 0x2002 → next request to 0x2000; the 2 old responses are dropped; the first fetch_addr_o is 0x2000.
- Branch coinciding with resp_valid_i, 1 outstanding → that response is dropped; discard_cnt_q=0 afterwards; no stale word is delivered.
- Branch to 0xFFFF_FFFC, two fetches → addresses 0xFFFF_FFFC, 0x0000_0000. A resp_err_i=1 on the second gives fetch_err_o=1 with fetch_addr_o=0x0.
